// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch channel: req/addr out of the core, ack/rdata back.
interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pc_fetch.sv
// PC register and fetch stage: fetches one instruction per req/ack, holds it
// for decode until the datapath retires it, then loads the selected next PC.
module pc_fetch #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              irq_in,
  input  logic [2:0]        pcsel,
  input  logic [15:0]       lit,
  input  logic [31:0]       ja,
  input  logic              exec_done,
  pc_fetch_if.master        imem,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              irq_ctl
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        irq_q, irq_d;

  logic [30:0] br_sum;
  logic [31:0] next_pc;

  // Supervisor bit is carried separately; the 31-bit adds wrap instead of carrying into it.
  assign pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};
  assign br_sum   = pc_plus4[30:0] + {{13{lit[15]}}, lit, 2'b00};

  always_comb begin
    next_pc = ILLOP_VEC;
    case (pcsel)
      3'd0:    next_pc = pc_plus4;
      3'd1:    next_pc = {pc_q[31], br_sum};
      3'd2:    next_pc = ja & {pc_q[31], {29{1'b1}}, 2'b00};
      3'd3:    next_pc = ILLOP_VEC;
      3'd4:    next_pc = XADR_VEC;
      default: next_pc = ILLOP_VEC;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    irq_d   = irq_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          irq_d   = irq_in & ~pc_q[31];
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (exec_done) begin
          pc_d    = next_pc & 32'hFFFF_FFFC;
          valid_d = 1'b0;
          irq_d   = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_VEC;
      instr_q <= '0;
      valid_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      irq_q   <= irq_d;
    end
  end

  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign irq_ctl        = irq_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: next-PC vector table plus handshake/reset corner sequences.
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        irq_in = 1'b0;
  logic [2:0]  pcsel = '0;
  logic [15:0] lit = '0;
  logic [31:0] ja = '0;
  logic        exec_done = 1'b0;
  logic [31:0] instr, pc, pc_plus4;
  logic        instr_valid, irq_ctl;

  pc_fetch_if bus();

  pc_fetch #(
    .RESET_VEC (32'h8000_0000),
    .ILLOP_VEC (32'h8000_0004),
    .XADR_VEC  (32'h8000_0008)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .irq_in      (irq_in),
    .pcsel       (pcsel),
    .lit         (lit),
    .ja          (ja),
    .exec_done   (exec_done),
    .imem        (bus.master),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .irq_ctl     (irq_ctl)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] start;
    logic [2:0]  sel;
    logic [15:0] lit;
    logic [31:0] ja;
    logic        irq;
    logic [31:0] exp_pc;
    logic [31:0] exp_p4;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    bus.imem_ack = 1'b0;
    exec_done = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic fetch(input logic [31:0] data, input logic irq);
    bus.imem_rdata = data;
    bus.imem_ack = 1'b1;
    irq_in = irq;
    tick();
    bus.imem_ack = 1'b0;
  endtask

  task automatic retire(input logic [2:0] sel, input logic [15:0] l, input logic [31:0] j);
    pcsel = sel;
    lit = l;
    ja = j;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
  endtask

  // From reset (supervisor) a JMP can reach any aligned target, user or supervisor.
  task automatic goto_pc(input logic [31:0] target);
    do_reset();
    fetch(32'h0, 1'b0);
    retire(3'd2, 16'h0, target);
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;

    vecs[0]  = '{32'h0000_0100, 3'd0, 16'h0000, 32'h0,          1'b0, 32'h0000_0104, 32'h0000_0104, 1'b0};
    vecs[1]  = '{32'h0000_0010, 3'd1, 16'hFFFE, 32'h0,          1'b0, 32'h0000_000C, 32'h0000_0014, 1'b0};
    vecs[2]  = '{32'h8000_0010, 3'd1, 16'h0001, 32'h0,          1'b0, 32'h8000_0018, 32'h8000_0014, 1'b0};
    vecs[3]  = '{32'h0000_0040, 3'd2, 16'h0000, 32'h8000_0123, 1'b0, 32'h0000_0120, 32'h0000_0044, 1'b0};
    vecs[4]  = '{32'h8000_0040, 3'd2, 16'h0000, 32'h8000_0123, 1'b0, 32'h8000_0120, 32'h8000_0044, 1'b0};
    vecs[5]  = '{32'h0000_0200, 3'd4, 16'h0000, 32'h0,          1'b1, 32'h8000_0008, 32'h0000_0204, 1'b1};
    vecs[6]  = '{32'h8000_0200, 3'd4, 16'h0000, 32'h0,          1'b1, 32'h8000_0008, 32'h8000_0204, 1'b0};
    vecs[7]  = '{32'h0000_0300, 3'd6, 16'h0000, 32'h0,          1'b0, 32'h8000_0004, 32'h0000_0304, 1'b0};
    vecs[8]  = '{32'h0000_0300, 3'd3, 16'h0000, 32'h0,          1'b0, 32'h8000_0004, 32'h0000_0304, 1'b0};
    vecs[9]  = '{32'h7FFF_FFFC, 3'd0, 16'h0000, 32'h0,          1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[10] = '{32'hFFFF_FFFC, 3'd0, 16'h0000, 32'h0,          1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0};
    vecs[11] = '{32'h0000_0004, 3'd1, 16'h8000, 32'h0,          1'b0, 32'h7FFE_0008, 32'h0000_0008, 1'b0};
    vecs[12] = '{32'h8000_0040, 3'd2, 16'h0000, 32'h0000_0457, 1'b0, 32'h0000_0454, 32'h8000_0044, 1'b0};
    vecs[13] = '{32'h0000_0500, 3'd7, 16'h0000, 32'h0,          1'b0, 32'h8000_0004, 32'h0000_0504, 1'b0};

    // Reset then first fetch, with an ack during the idle cycle that must be ignored.
    reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_irq", irq_ctl, 1'b0);
    chk("rst_instr", instr, 32'h0);
    reset_n = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("idle_req", bus.imem_req, 1'b0);
    tick();
    bus.imem_ack = 1'b0;
    chk("fetch_req", bus.imem_req, 1'b1);
    chk("fetch_addr", bus.imem_addr, 32'h8000_0000);
    chk("idle_ack_valid", instr_valid, 1'b0);
    chk("idle_ack_instr", instr, 32'h0);
    fetch(32'h1234_5678, 1'b0);
    chk("first_instr", instr, 32'h1234_5678);
    chk("first_valid", instr_valid, 1'b1);
    chk("exec_req", bus.imem_req, 1'b0);

    // Wait states: address held until ack, then sequential retire.
    goto_pc(32'h0000_0100);
    for (int unsigned w = 0; w < 3; w++) begin
      chk("wait_addr", bus.imem_addr, 32'h0000_0100);
      chk("wait_req", bus.imem_req, 1'b1);
      chk("wait_valid", instr_valid, 1'b0);
      tick();
    end
    fetch(32'hCAFE_0001, 1'b0);
    chk("wait_instr", instr, 32'hCAFE_0001);
    retire(3'd0, 16'h0, 32'h0);
    chk("seq_pc", pc, 32'h0000_0104);
    chk("seq_valid", instr_valid, 1'b0);
    chk("seq_req", bus.imem_req, 1'b1);

    // exec_done while fetching is ignored.
    retire(3'd2, 16'h0, 32'h0000_0800);
    chk("fetch_done_pc", pc, 32'h0000_0104);
    chk("fetch_done_req", bus.imem_req, 1'b1);

    // ack while executing is ignored.
    fetch(32'h1111_1111, 1'b0);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h2222_2222;
    tick();
    bus.imem_ack = 1'b0;
    chk("exec_ack_instr", instr, 32'h1111_1111);
    chk("exec_ack_valid", instr_valid, 1'b1);

    // irq_ctl is latched at fetch and held through EXEC despite irq_in dropping.
    goto_pc(32'h0000_0200);
    fetch(32'h3333_3333, 1'b1);
    irq_in = 1'b0;
    repeat (2) tick();
    chk("irq_hold", irq_ctl, 1'b1);
    retire(3'd4, 16'h0, 32'h0);
    chk("irq_clear", irq_ctl, 1'b0);

    for (int i = 0; i < 14; i++) begin
      goto_pc(vecs[i].start);
      chk($sformatf("v%0d_start", i), pc, vecs[i].start);
      fetch(32'hA500_0000 | i, vecs[i].irq);
      irq_in = 1'b0;
      chk($sformatf("v%0d_irq", i), irq_ctl, vecs[i].exp_irq);
      chk($sformatf("v%0d_plus4", i), pc_plus4, vecs[i].exp_p4);
      chk($sformatf("v%0d_valid", i), instr_valid, 1'b1);
      retire(vecs[i].sel, vecs[i].lit, vecs[i].ja);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_req", i), bus.imem_req, 1'b1);
    end

    // Asynchronous reset during EXEC takes effect without a clock edge.
    goto_pc(32'h0000_0600);
    fetch(32'h4444_4444, 1'b1);
    chk("pre_rst_valid", instr_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", instr_valid, 1'b0);
    chk("arst_req", bus.imem_req, 1'b0);
    chk("arst_pc", pc, 32'h8000_0000);
    chk("arst_irq", irq_ctl, 1'b0);
    chk("arst_instr", instr, 32'h0);
    irq_in = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
